// File: rtl/control_cpu.sv
// control_cpu: multi-cycle control sequencer for the 32-bit CPU datapath.
// One instruction in flight; FETCH -> DECODE -> EXEC -> MEM -> WB as needed.
// Outputs are combinational from the state and the current opcode/funct.
// Optional build macro: CONTROL_CPU_ILLEGAL_HALT_EN (illegal opcode -> HALT
// until rst); when undefined an illegal opcode runs as a 2-cycle nop.
// Ports:
//   clk, rst                     clock (rising), async active-high reset
//   opcode, funct                decoded instruction fields
//   is_alu_zero                  ALU zero flag (beq outcome)
//   is_full_rnum1/2              pending-write hazards on rs / rt
//   is_load_PC, control_mux_for_PC  PC strobe and source (0 +1, 1 +IMM, 2 jump)
//   is_write_reg/mem, is_write_from_mem  write enables and write-back source
//   opcode_alu                   ALU operation
//   is_R_type/is_I_type/is_J_type instruction class flags
//   is_nop                       idle or stalled; clears hazard bookkeeping
module control_cpu #(
  parameter logic [5:0] OPC_ADD = 6'b100000,
  parameter logic [5:0] OPC_SUB = 6'b100010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       is_alu_zero,
  input  logic       is_full_rnum1,
  input  logic       is_full_rnum2,
  output logic       is_load_PC,
  output logic [1:0] control_mux_for_PC,
  output logic       is_write_reg,
  output logic       is_write_mem,
  output logic       is_write_from_mem,
  output logic [5:0] opcode_alu,
  output logic       is_R_type,
  output logic       is_I_type,
  output logic       is_J_type,
  output logic       is_nop
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_IMM = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, state_next;

  // Instruction class decode
  logic op_r, op_addi, op_lw, op_sw, op_beq, op_j, op_legal;
  logic reads_rs, reads_rt, stall;
  logic [5:0] alu_op;

  assign op_r     = (opcode == OP_R);
  assign op_addi  = (opcode == OP_ADDI);
  assign op_lw    = (opcode == OP_LW);
  assign op_sw    = (opcode == OP_SW);
  assign op_beq   = (opcode == OP_BEQ);
  assign op_j     = (opcode == OP_J);
  assign op_legal = op_r | op_addi | op_lw | op_sw | op_beq | op_j;

  // Only operands the instruction actually reads can hold it in DECODE
  assign reads_rs = op_r | op_addi | op_lw | op_sw | op_beq;
  assign reads_rt = op_r | op_sw | op_beq;
  assign stall    = (is_full_rnum1 & reads_rs) | (is_full_rnum2 & reads_rt);

  always_comb begin
    alu_op = 6'd0;
    if (op_r)                           alu_op = funct;
    else if (op_addi | op_lw | op_sw)   alu_op = OPC_ADD;
    else if (op_beq)                    alu_op = OPC_SUB;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next state and control outputs
  always_comb begin
    state_next         = state;
    is_load_PC         = 1'b0;
    control_mux_for_PC = PC_SEQ;
    is_write_reg       = 1'b0;
    is_write_mem       = 1'b0;
    is_write_from_mem  = 1'b0;
    opcode_alu         = 6'd0;
    is_R_type          = 1'b0;
    is_I_type          = 1'b0;
    is_J_type          = 1'b0;
    is_nop             = 1'b0;

    // Class flags and ALU op stay valid for the whole instruction body
    if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
      is_R_type  = op_r;
      is_I_type  = op_addi | op_lw | op_sw | op_beq;
      is_J_type  = op_j;
      opcode_alu = alu_op;
    end

    case (state)
      S_FETCH: begin
        is_nop     = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (!op_legal) begin
          is_nop     = 1'b1;
`ifdef CONTROL_CPU_ILLEGAL_HALT_EN
          state_next = S_HALT;
`else
          is_load_PC = 1'b1;
          state_next = S_FETCH;
`endif
        end else if (stall) begin
          is_nop     = 1'b1;
          state_next = S_DECODE;
        end else if (op_j) begin
          is_load_PC         = 1'b1;
          control_mux_for_PC = PC_JMP;
          state_next         = S_FETCH;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_beq) begin
          is_load_PC         = 1'b1;
          control_mux_for_PC = is_alu_zero ? PC_IMM : PC_SEQ;
          state_next         = S_FETCH;
        end else if (op_lw | op_sw) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (op_sw) begin
          is_write_mem = 1'b1;
          is_load_PC   = 1'b1;
          state_next   = S_FETCH;
        end else begin
          is_write_from_mem = 1'b1;
          state_next        = S_WB;
        end
      end
      S_WB: begin
        is_write_reg      = 1'b1;
        is_load_PC        = 1'b1;
        is_write_from_mem = op_lw;
        state_next        = S_FETCH;
      end
      S_HALT: begin
        is_nop     = 1'b1;
        state_next = S_HALT;
      end
      default: begin
        is_nop     = 1'b1;
        state_next = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_control_cpu.sv
// tb_control_cpu: randomized self-checking bench for control_cpu.
// A cycle-count model predicts every output on every cycle; a few directed
// instructions also pin literal values at hand-computed cycle numbers.
// Honours CONTROL_CPU_ILLEGAL_HALT_EN the same way as the design.
module tb_control_cpu;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       is_alu_zero, is_full_rnum1, is_full_rnum2;
  logic       is_load_PC;
  logic [1:0] control_mux_for_PC;
  logic       is_write_reg, is_write_mem, is_write_from_mem;
  logic [5:0] opcode_alu;
  logic       is_R_type, is_I_type, is_J_type, is_nop;

  control_cpu dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .is_alu_zero(is_alu_zero), .is_full_rnum1(is_full_rnum1), .is_full_rnum2(is_full_rnum2),
    .is_load_PC(is_load_PC), .control_mux_for_PC(control_mux_for_PC),
    .is_write_reg(is_write_reg), .is_write_mem(is_write_mem),
    .is_write_from_mem(is_write_from_mem), .opcode_alu(opcode_alu),
    .is_R_type(is_R_type), .is_I_type(is_I_type), .is_J_type(is_J_type), .is_nop(is_nop)
  );

  always #5 clk = ~clk;

  // {load, mux[1:0], wreg, wmem, wfm, alu[5:0], R, I, J, nop}
  logic [15:0] dut_vec;
  assign dut_vec = {is_load_PC, control_mux_for_PC, is_write_reg, is_write_mem,
                    is_write_from_mem, opcode_alu, is_R_type, is_I_type, is_J_type, is_nop};

  int          n_vec = 0;
  int          n_bad = 0;
  logic        chk_en = 1'b0;
  logic [15:0] exp_vec = 16'h0001;
  int          cur_p = 0;

  function automatic int cpi_of(input logic [5:0] opc);
    case (opc)
      6'b000010: return 2;
      6'b000100: return 3;
      6'b101011: return 4;
      6'b000000: return 4;
      6'b001000: return 4;
      6'b100011: return 5;
      default:   return 2;
    endcase
  endfunction

  function automatic logic rd_rs(input logic [5:0] opc);
    return (opc == 6'b000000) || (opc == 6'b001000) || (opc == 6'b100011) ||
           (opc == 6'b101011) || (opc == 6'b000100);
  endfunction

  function automatic logic rd_rt(input logic [5:0] opc);
    return (opc == 6'b000000) || (opc == 6'b101011) || (opc == 6'b000100);
  endfunction

  // Expected outputs at position p of an instruction (0 = fetch, 1 = decode)
  function automatic logic [15:0] model_out(input logic [5:0] opc, input logic [5:0] fn,
                                            input int p, input logic stl, input logic z);
    logic r, ad, l, s, b, j;
    logic ld, wr, wm, wf;
    logic [1:0] mx;
    logic [5:0] alu;
    r  = (opc == 6'b000000); ad = (opc == 6'b001000); l = (opc == 6'b100011);
    s  = (opc == 6'b101011); b  = (opc == 6'b000100); j = (opc == 6'b000010);
    if (p == 0) return 16'h0001;
    if (!(r || ad || l || s || b || j)) begin
`ifdef CONTROL_CPU_ILLEGAL_HALT_EN
      return 16'h0001;
`else
      return 16'h8001;
`endif
    end
    alu = r ? fn : (ad || l || s) ? 6'b100000 : b ? 6'b100010 : 6'd0;
    ld = 1'b0; mx = 2'd0; wr = 1'b0; wm = 1'b0; wf = 1'b0;
    if (!stl && p == cpi_of(opc) - 1) begin
      ld = 1'b1;
      mx = j ? 2'd2 : (b && z) ? 2'd1 : 2'd0;
      wr = r || ad || l;
      wm = s;
      wf = l;
    end
    if (l && p == 3) wf = 1'b1;
    return {ld, mx, wr, wm, wf, alu, r, ad || l || s || b, j, stl};
  endfunction

  // Single compare process, every cycle while checking is enabled
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL cycle-check op=%b p=%0d got=%h want=%h", opcode, cur_p, dut_vec, exp_vec);
      end
    end
  end

  task automatic step(input int cyc, input int pin_cyc, input logic [15:0] pin, input bit rst_now);
    @(negedge clk);
    if (cyc == pin_cyc) begin
      n_vec++;
      if (dut_vec !== pin) begin
        n_bad++;
        $display("FAIL pin op=%b cycle=%0d got=%h want=%h", opcode, cyc, dut_vec, pin);
      end
    end
    if (rst_now) begin
      #2 rst = 1'b1;
      #1 n_vec++;
      if (is_write_reg !== 1'b0 || is_load_PC !== 1'b0 || is_nop !== 1'b1) begin
        n_bad++;
        $display("FAIL async-reset got wreg=%b load=%b nop=%b want 0 0 1",
                 is_write_reg, is_load_PC, is_nop);
      end
    end
    @(posedge clk);
    #1;
    if (rst_now) rst = 1'b0;
  endtask

  // h2_n < 0: random hazards; otherwise rnum2 held high for h2_n decode cycles.
  // zm < 0: random zero flag; otherwise forced.
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int h2_n,
                           input int zm, input int pin_cyc, input logic [15:0] pin,
                           input bit rst_last);
    int cpi, cyc, dcnt;
    logic stl, z;
    cpi = cpi_of(opc);
    cyc = 1;
    dcnt = 0;
    opcode = opc;
    funct = fn;
    is_full_rnum1 = 1'($urandom_range(0, 1));
    is_full_rnum2 = 1'($urandom_range(0, 1));
    is_alu_zero = 1'($urandom_range(0, 1));
    cur_p = 0;
    exp_vec = model_out(opc, fn, 0, 1'b0, 1'b0);
    step(cyc, pin_cyc, pin, 1'b0);
    cyc++;
    cur_p = 1;
    do begin
      if (h2_n >= 0) begin
        is_full_rnum1 = 1'b0;
        is_full_rnum2 = (dcnt < h2_n);
      end else if (dcnt >= 6) begin
        is_full_rnum1 = 1'b0;
        is_full_rnum2 = 1'b0;
      end else begin
        is_full_rnum1 = ($urandom_range(0, 2) == 0);
        is_full_rnum2 = ($urandom_range(0, 2) == 0);
      end
      is_alu_zero = 1'($urandom_range(0, 1));
      stl = (is_full_rnum1 && rd_rs(opc)) || (is_full_rnum2 && rd_rt(opc));
      exp_vec = model_out(opc, fn, 1, stl, 1'b0);
      step(cyc, pin_cyc, pin, rst_last && !stl && cpi == 2);
      cyc++;
      dcnt++;
    end while (stl);
    for (int p = 2; p < cpi; p++) begin
      cur_p = p;
      z = (zm >= 0) ? zm[0] : 1'($urandom_range(0, 1));
      is_alu_zero = z;
      is_full_rnum1 = 1'($urandom_range(0, 1));
      is_full_rnum2 = 1'($urandom_range(0, 1));
      exp_vec = model_out(opc, fn, p, 1'b0, z);
      step(cyc, pin_cyc, pin, rst_last && p == cpi - 1);
      cyc++;
    end
`ifdef CONTROL_CPU_ILLEGAL_HALT_EN
    if (cpi_of(opc) == 2 && opc != 6'b000010) begin
      exp_vec = 16'h0001;
      for (int k = 0; k < 20; k++) begin
        opcode = 6'($urandom_range(0, 63));
        is_full_rnum1 = 1'($urandom_range(0, 1));
        step(cyc, 0, 16'h0, 1'b0);
        cyc++;
      end
      rst = 1'b1;
      step(cyc, 0, 16'h0, 1'b0);
      rst = 1'b0;
    end
`endif
  endtask

  logic [5:0] ops [7] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b111111};

  initial begin
    rst = 1'b1;
    opcode = 6'b000000;
    funct = 6'b100000;
    is_alu_zero = 1'b0;
    is_full_rnum1 = 1'b0;
    is_full_rnum2 = 1'b0;
    exp_vec = 16'h0001;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // R-type add: write in cycle 4
    run_instr(6'b000000, 6'b100000, 0, -1, 4,
              {1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 6'b100000, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b0);
    // lw: write-back from memory in cycle 5
    run_instr(6'b100011, 6'd0, 0, -1, 5,
              {1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b0);
    run_instr(6'b100011, 6'd0, 0, -1, 4,
              {1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b0);
    // beq taken / not taken
    run_instr(6'b000100, 6'd0, 0, 1, 3,
              {1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 6'b100010, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b0);
    run_instr(6'b000100, 6'd0, 0, 0, 3,
              {1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 6'b100010, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b0);
    // sw stalled 3 cycles on rt: memory write in cycle 7
    run_instr(6'b101011, 6'd0, 3, -1, 3,
              {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b1}, 1'b0);
    run_instr(6'b101011, 6'd0, 3, -1, 7,
              {1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b0);
    // addi ignores rt hazard
    run_instr(6'b001000, 6'd0, 5, -1, 4,
              {1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b0);
    // j
    run_instr(6'b000010, 6'd0, 0, -1, 2,
              {1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b0);
    // illegal opcode
`ifdef CONTROL_CPU_ILLEGAL_HALT_EN
    run_instr(6'b111111, 6'd0, 0, -1, 2, 16'h0001, 1'b0);
`else
    run_instr(6'b111111, 6'd0, 0, -1, 2,
              {1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0);
`endif
    // reset during the WB cycle of an R-type
    run_instr(6'b000000, 6'b100100, 0, -1, 0, 16'h0, 1'b1);
    run_instr(6'b000000, 6'b100010, 0, -1, 4,
              {1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 6'b100010, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b0);

    // Randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      logic [5:0] o;
      o = ops[$urandom_range(0, 6)];
      if (o == 6'b111111) o = 6'($urandom_range(0, 63));
      run_instr(o, 6'($urandom_range(0, 63)), -1, -1, 0, 16'h0, ($urandom_range(0, 9) == 0));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after 200000 time units");
    $fatal(1);
  end

endmodule
